// File: rtl/gameconsole_pkg.sv
// Shared game console constants: screen geometry,
// line buffer widths and line timing.
package gameconsole_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int LINE_CYCLE_MAX = 1600;
  localparam int LINE_CYCLES_PER_PIXEL = 4;

  localparam int LINEBUFF_BANK_W = 1;
  localparam int LINEBUFF_ADDR_W = 9;
  localparam int LINEBUFF_DATA_W = 32;

  localparam logic [LINEBUFF_DATA_W-1:0]
    LINEBUFF_CLEAR_COLOR = 32'h0000_0000;

endpackage

// File: rtl/vpu_line_scanout_sweep.sv
// Reset-time clear sweep over both line buffer banks:
// addr runs 0..SCAN_W-1, then the bank steps.
module vpu_line_scanout_sweep
  import gameconsole_pkg::*;
#(
  parameter int SCAN_W = SCREEN_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en_i,
  output logic                       bank_o,
  output logic [LINEBUFF_ADDR_W-1:0] addr_o,
  output logic                       we_o,
  output logic                       done_o
);

  localparam logic [LINEBUFF_ADDR_W-1:0] LAST_A =
    LINEBUFF_ADDR_W'(SCAN_W - 1);

  logic [LINEBUFF_ADDR_W-1:0] addr_q, addr_d;
  logic                       bank_q, bank_d;

  // next sweep position, one entry per enabled cycle
  always_comb begin
    addr_d = addr_q;
    bank_d = bank_q;
    if (en_i) begin
      if (addr_q == LAST_A) begin
        addr_d = '0;
        bank_d = ~bank_q;
      end else begin
        addr_d = addr_q + LINEBUFF_ADDR_W'(1);
      end
    end
  end

  // sweep position register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      bank_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      bank_q <= bank_d;
    end
  end

  assign bank_o = bank_q;
  assign addr_o = addr_q;
  assign we_o   = en_i;
  assign done_o = en_i && bank_q && (addr_q == LAST_A);

endmodule

// File: rtl/vpu_line_scanout.sv
// Streams the previous sprite line out of the idle
// line buffer bank, clearing each entry after reading.
module vpu_line_scanout
  import gameconsole_pkg::*;
#(
  parameter logic [LINEBUFF_DATA_W-1:0] BG_COLOR =
    LINEBUFF_CLEAR_COLOR,
  parameter int SCAN_W = SCREEN_W,
  parameter int SCAN_H = SCREEN_H
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [10:0]                line_cycle,
  input  logic [8:0]                 y,
  output logic                       line_ena,
  output logic                       line_wea,
  output logic [LINEBUFF_BANK_W-1:0] line_banka,
  output logic [LINEBUFF_ADDR_W-1:0] line_addra,
  output logic [LINEBUFF_DATA_W-1:0] line_dina,
  input  logic [LINEBUFF_DATA_W-1:0] line_douta,
  output logic                       init_done,
  output logic                       pix_valid,
  output logic [8:0]                 pix_x,
  output logic [8:0]                 pix_y,
  output logic [23:0]                pix_rgb,
  output logic                       line_done,
  output logic                       scan_err
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    SCAN
  } vpu_line_scanout_state_t;

  localparam logic [8:0] LAST_K = 9'(SCAN_W - 1);
  localparam logic [8:0] MAX_Y  = 9'(SCAN_H);

  vpu_line_scanout_state_t state_q, state_d;

  logic        init_done_q, init_done_d;
  logic        pix_valid_q, pix_valid_d;
  logic [8:0]  pix_x_q, pix_x_d;
  logic [8:0]  pix_y_q, pix_y_d;
  logic [23:0] pix_rgb_q, pix_rgb_d;
  logic        line_done_q, line_done_d;
  logic        scan_err_q, scan_err_d;

  logic [8:0] k;
  logic [1:0] ph;
  logic       lc_zero;
  logic       start_ok;
  logic       slot_act;
  logic       scan_now;

  logic                       sw_bank;
  logic [LINEBUFF_ADDR_W-1:0] sw_addr;
  logic                       sw_we;
  logic                       sw_done;

  assign k        = line_cycle[10:2];
  assign ph       = line_cycle[1:0];
  assign lc_zero  = (line_cycle == 11'd0);
  assign start_ok = lc_zero && (y != 9'd0) && (y <= MAX_Y);
  assign slot_act = (k <= LAST_K);

  vpu_line_scanout_sweep #(
    .SCAN_W(SCAN_W)
  ) u_sweep (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (state_q == CLEAR),
    .bank_o(sw_bank),
    .addr_o(sw_addr),
    .we_o  (sw_we),
    .done_o(sw_done)
  );

  // next state, port A access and pixel capture
  always_comb begin
    state_d     = state_q;
    init_done_d = init_done_q;
    pix_valid_d = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_rgb_d   = pix_rgb_q;
    line_done_d = 1'b0;
    scan_err_d  = scan_err_q;
    scan_now    = 1'b0;
    line_ena    = 1'b0;
    line_wea    = 1'b0;
    line_banka  = '0;
    line_addra  = '0;
    line_dina   = '0;

    unique case (state_q)
      CLEAR: begin
        line_ena   = sw_we;
        line_wea   = sw_we;
        line_banka = LINEBUFF_BANK_W'(sw_bank);
        line_addra = sw_addr;
        line_dina  = BG_COLOR;
        if (sw_done) begin
          state_d     = IDLE;
          init_done_d = 1'b1;
        end
      end
      IDLE: scan_now = start_ok;
      SCAN: begin
        if (lc_zero) begin
          scan_err_d = 1'b1;
          scan_now   = start_ok;
        end else begin
          scan_now = 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase

    if (scan_now) begin
      state_d = SCAN;
      if (slot_act) begin
        line_banka = LINEBUFF_BANK_W'(~y[0]);
        line_addra = LINEBUFF_ADDR_W'(k);
        unique case (ph)
          2'd0: line_ena = 1'b1;
          2'd1: begin
            pix_valid_d = 1'b1;
            pix_x_d     = k;
            pix_y_d     = y - 9'd1;
            pix_rgb_d   = (line_douta[31:24] == 8'd0)
                        ? BG_COLOR[23:0]
                        : line_douta[23:0];
          end
          2'd2: begin
            line_ena  = 1'b1;
            line_wea  = 1'b1;
            line_dina = BG_COLOR;
            if (k == LAST_K) begin
              state_d     = IDLE;
              line_done_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end else if (state_q == SCAN) begin
      state_d = IDLE;
    end

    if (!rst_n) begin
      line_ena   = 1'b0;
      line_wea   = 1'b0;
      line_banka = '0;
      line_addra = '0;
      line_dina  = '0;
    end
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      init_done_q <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_rgb_q   <= '0;
      line_done_q <= 1'b0;
      scan_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= init_done_d;
      pix_valid_q <= pix_valid_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_rgb_q   <= pix_rgb_d;
      line_done_q <= line_done_d;
      scan_err_q  <= scan_err_d;
    end
  end

  assign init_done = init_done_q;
  assign pix_valid = pix_valid_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_rgb   = pix_rgb_q;
  assign line_done = line_done_q;
  assign scan_err  = scan_err_q;

endmodule
